// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Package fifo_arb_pkg: arbiter state enum and the rotating pick function.
package fifo_arb_pkg;

   localparam int unsigned MAX_NREQ  = 16;
   localparam int unsigned MAX_IDX_W = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                 found;
      logic [MAX_IDX_W-1:0] idx;
   } pick_t;

   // First asserted bit of valid, searching ptr, ptr+1, ... and wrapping at nreq-1.
   function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0]  valid,
                                     input logic [MAX_IDX_W-1:0] ptr,
                                     input int unsigned          nreq);
      pick_t       r;
      int unsigned cand;
      r = '0;
      for (int unsigned k = 0; k < MAX_NREQ; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= nreq) cand = cand - nreq;
         if (k < nreq && !r.found && valid[cand[MAX_IDX_W-1:0]]) begin
            r.found = 1'b1;
            r.idx   = cand[MAX_IDX_W-1:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side and FIFO-write-side signals of the arbiter.
// master: the environment (producers plus the FIFO full flag); slave: the arbiter.
interface fifo_write_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_last;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_full;
   logic                  fifo_shift_in;
   logic [WIDTH-1:0]      fifo_wdata;

   modport master (
      output req_valid, req_last, req_data, fifo_full,
      input  req_ready, fifo_shift_in, fifo_wdata
   );

   modport slave (
      input  req_valid, req_last, req_data, fifo_full,
      output req_ready, fifo_shift_in, fifo_wdata
   );
endinterface

// File: rtl/fifo_write_arbiter_pick.sv
// Rotating priority encoder: lowest-distance valid requester from ptr.
module rr_priority_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  valid,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [MAX_NREQ-1:0]  valid_ext;
   logic [MAX_IDX_W-1:0] ptr_ext;
   pick_t                pick;

   // Widen to the package's fixed width, pick, and narrow the index back.
   always_comb begin
      valid_ext             = '0;
      valid_ext[NREQ-1:0]   = valid;
      ptr_ext               = '0;
      ptr_ext[IDX_W-1:0]    = ptr;
      pick                  = rr_pick(valid_ext, ptr_ext, int'(NREQ));
      found                 = pick.found;
      idx                   = pick.idx[IDX_W-1:0];
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// with packet lock so multi-word packets are never interleaved.
// Optional macro ARB_TIMEOUT_EN: force-release a lock whose owner stays idle
// for TIMEOUT cycles and pulse timeout_err.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int WIDTH   = 8,
   parameter  int NREQ    = 4,
   parameter  int TIMEOUT = 16,
   localparam int IDX_W   = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 res_n,
   fifo_write_arbiter_if.slave  bus,
   output logic                 locked,
   output logic [IDX_W-1:0]     lock_id,
   output logic                 timeout_err
);

   if (NREQ < 2 || NREQ > int'(MAX_NREQ)) begin : g_bad_nreq
      $error("fifo_write_arbiter: NREQ must be 2..16");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fifo_write_arbiter: TIMEOUT must be at least 1");
   end

   arb_state_t       state, state_nxt;
   logic [IDX_W-1:0] rr_ptr, rr_nxt, lock_nxt;
   logic [IDX_W-1:0] pick_idx, grant_idx;
   logic             pick_found, grant_vld, grant_last;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(NREQ - 1)) ? '0 : i + 1'b1;
   endfunction

   rr_priority_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .valid (bus.req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Grant: round-robin pick when idle, owner only when locked; nothing while full or in reset.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = rr_ptr;
      if (res_n && !bus.fifo_full) begin
         if (state == IDLE) begin
            grant_vld = pick_found;
            grant_idx = pick_idx;
         end else begin
            grant_vld = bus.req_valid[lock_id];
            grant_idx = lock_id;
         end
      end
   end

   assign grant_last        = bus.req_last[grant_idx];
   assign bus.fifo_shift_in = grant_vld;
   assign locked            = (state == LOCKED);

   // Steer the granted producer onto the FIFO write port; zero data when idle.
   always_comb begin
      bus.req_ready  = '0;
      bus.fifo_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_vld && grant_idx == IDX_W'(i)) begin
            bus.req_ready[i] = 1'b1;
            bus.fifo_wdata   = bus.req_data[i*WIDTH +: WIDTH];
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
   logic             tmo_err_nxt;
`endif

   // Next state, rotation pointer, lock owner (and idle-owner counter when enabled).
   always_comb begin
      state_nxt   = state;
      rr_nxt      = rr_ptr;
      lock_nxt    = lock_id;
`ifdef ARB_TIMEOUT_EN
      tmo_nxt     = tmo_cnt;
      tmo_err_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (grant_vld) begin
               rr_nxt = next_idx(grant_idx);
               if (!grant_last) begin
                  state_nxt = LOCKED;
                  lock_nxt  = grant_idx;
               end
            end
         end
         LOCKED: begin
            if (grant_vld) begin
`ifdef ARB_TIMEOUT_EN
               tmo_nxt = '0;
`endif
               if (grant_last) begin
                  state_nxt = IDLE;
                  rr_nxt    = next_idx(lock_id);
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (res_n && !bus.fifo_full && !bus.req_valid[lock_id]) begin
               if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                  state_nxt   = IDLE;
                  rr_nxt      = next_idx(lock_id);
                  tmo_nxt     = '0;
                  tmo_err_nxt = 1'b1;
               end else begin
                  tmo_nxt = tmo_cnt + 1'b1;
               end
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, pointer and owner registers.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         lock_id <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_nxt;
         lock_id <= lock_nxt;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Idle-owner counter and the one-cycle forced-release pulse.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         tmo_cnt     <= tmo_nxt;
         timeout_err <= tmo_err_nxt;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: NREQ=4, WIDTH=8, 8-entry FIFO model.
module tb_fifo_write_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       res_n;
   logic [3:0] valid, last;
   logic [7:0] d0, d1, d2, d3;
   logic       locked;
   logic [1:0] lock_id;
   logic       timeout_err;

   logic [7:0] fmem [8];
   logic [2:0] fwp  = '0;
   logic [2:0] frp  = '0;
   logic [3:0] fcnt = '0;
   logic       fpop = 1'b0;

   int checks = 0;
   int errors = 0;

   fifo_write_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

   assign bus.req_valid = valid;
   assign bus.req_last  = last;
   assign bus.req_data  = {d3, d2, d1, d0};
   assign bus.fifo_full = (fcnt == 4'd8);

   fifo_write_arbiter #(
      .WIDTH   (8),
      .NREQ    (4),
      .TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .res_n       (res_n),
      .bus         (bus),
      .locked      (locked),
      .lock_id     (lock_id),
      .timeout_err (timeout_err)
   );

   // RAMfifo stand-in, 8 entries.
   always @(posedge clk) begin
      if (bus.fifo_shift_in && fcnt != 4'd8) begin
         fmem[fwp] <= bus.fifo_wdata;
         fwp       <= fwp + 3'd1;
      end
      if (fpop && fcnt != 4'd0) frp <= frp + 3'd1;
      fcnt <= fcnt + ((bus.fifo_shift_in && fcnt != 4'd8) ? 4'd1 : 4'd0)
                   - ((fpop && fcnt != 4'd0) ? 4'd1 : 4'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_port(input string tag, input logic [3:0] rdy, input logic sh, input logic [7:0] wd);
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'(rdy));
      chk({tag, "_shift"}, 32'(bus.fifo_shift_in), 32'(sh));
      chk({tag, "_wdata"}, 32'(bus.fifo_wdata), 32'(wd));
   endtask

   task automatic expect_fifo(input string tag, input logic [7:0] exp);
      chk({tag, "_notempty"}, 32'(fcnt != 4'd0), 32'd1);
      chk(tag, 32'(fmem[frp]), 32'(exp));
      fpop = 1'b1;
      tick();
      fpop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] dtab [4];
      logic [1:0] seq1 [5];
      logic [1:0] seq3 [8];
      dtab = '{8'h10, 8'h21, 8'h32, 8'h43};
      seq1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      seq3 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      res_n = 1'b0;
      valid = 4'b1111;
      last  = 4'b1111;
      d0 = 8'h10; d1 = 8'h21; d2 = 8'h32; d3 = 8'h43;

      // Reset state, outputs forced low despite pending requests
      tick();
      tick();
      chk_port("rst", 4'b0000, 1'b0, 8'h00);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_lock_id", 32'(lock_id), 32'd0);
      chk("rst_tmo", 32'(timeout_err), 32'd0);

      // 1: all valid, single-word packets -> 0,1,2,3,0
      res_n = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk_port("t1", 4'b0001 << seq1[i], 1'b1, dtab[seq1[i]]);
         chk("t1_locked", 32'(locked), 32'd0);
         tick();
      end
      valid = 4'b0000;
      for (int i = 0; i < 5; i++) expect_fifo("t1_fifo", dtab[seq1[i]]);
      chk("t1_empty", 32'(fcnt), 32'd0);

      // 2: requester 2 packet A1..A3 while requester 0 is valid (rr_ptr=1)
      valid = 4'b0101; last = 4'b0001; d2 = 8'hA1;
      #1;
      chk_port("t2_a1", 4'b0100, 1'b1, 8'hA1);
      tick();
      d2 = 8'hA2;
      #1;
      chk_port("t2_a2", 4'b0100, 1'b1, 8'hA2);
      chk("t2_locked", 32'(locked), 32'd1);
      chk("t2_lock_id", 32'(lock_id), 32'd2);
      tick();
      d2 = 8'hA3; last = 4'b0101;
      #1;
      chk_port("t2_a3", 4'b0100, 1'b1, 8'hA3);
      chk("t2_locked3", 32'(locked), 32'd1);
      tick();
      valid = 4'b0001;
      #1;
      chk_port("t2_r0", 4'b0001, 1'b1, 8'h10);
      chk("t2_unlocked", 32'(locked), 32'd0);
      tick();
      valid = 4'b0000; d2 = 8'h32; last = 4'b1111;
      expect_fifo("t2_fifo_a1", 8'hA1);
      expect_fifo("t2_fifo_a2", 8'hA2);
      expect_fifo("t2_fifo_a3", 8'hA3);
      expect_fifo("t2_fifo_r0", 8'h10);

      // 3: fill to full (rr_ptr=1), then pop one
      valid = 4'b1111;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk_port("t3_fill", 4'b0001 << seq3[i], 1'b1, dtab[seq3[i]]);
         tick();
      end
      #1;
      chk("t3_full", 32'(bus.fifo_full), 32'd1);
      chk_port("t3_blocked", 4'b0000, 1'b0, 8'h00);
      tick();
      chk_port("t3_blocked2", 4'b0000, 1'b0, 8'h00);
      expect_fifo("t3_pop", 8'h21);
      chk_port("t3_refill", 4'b0010, 1'b1, 8'h21);
      tick();
      chk_port("t3_full_again", 4'b0000, 1'b0, 8'h00);
      valid = 4'b0000;
      expect_fifo("t3_f0", 8'h32);
      expect_fifo("t3_f1", 8'h43);
      expect_fifo("t3_f2", 8'h10);
      expect_fifo("t3_f3", 8'h21);
      expect_fifo("t3_f4", 8'h32);
      expect_fifo("t3_f5", 8'h43);
      expect_fifo("t3_f6", 8'h10);
      expect_fifo("t3_f7", 8'h21);

      // 4: owner 1 stalls 5 cycles while requester 3 waits (rr_ptr=2)
      valid = 4'b0010; last = 4'b0000; d1 = 8'hB1;
      #1;
      chk_port("t4_b1", 4'b0010, 1'b1, 8'hB1);
      tick();
      valid = 4'b1000; last = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk_port("t4_stall", 4'b0000, 1'b0, 8'h00);
         chk("t4_locked", 32'(locked), 32'd1);
         chk("t4_lock_id", 32'(lock_id), 32'd1);
         tick();
      end
      valid = 4'b1010; last = 4'b1010; d1 = 8'hB2;
      #1;
      chk_port("t4_b2", 4'b0010, 1'b1, 8'hB2);
      tick();
      valid = 4'b1000;
      #1;
      chk_port("t4_r3", 4'b1000, 1'b1, 8'h43);
      tick();
      valid = 4'b0000; d1 = 8'h21; last = 4'b1111;
      expect_fifo("t4_fifo_b1", 8'hB1);
      expect_fifo("t4_fifo_b2", 8'hB2);
      expect_fifo("t4_fifo_r3", 8'h43);

      // 5: reset mid-packet of owner 1 (rr_ptr=0 -> 2 after the first word)
      valid = 4'b0010; last = 4'b0000; d1 = 8'hC1;
      #1;
      chk_port("t5_c1", 4'b0010, 1'b1, 8'hC1);
      tick();
      chk("t5_locked", 32'(locked), 32'd1);
      res_n = 1'b0; valid = 4'b1011; last = 4'b1111;
      #1;
      chk_port("t5_rst", 4'b0000, 1'b0, 8'h00);
      chk("t5_rst_locked", 32'(locked), 32'd0);
      chk("t5_rst_lock_id", 32'(lock_id), 32'd0);
      tick();
      chk_port("t5_rst2", 4'b0000, 1'b0, 8'h00);
      tick();
      res_n = 1'b1;
      #1;
      chk_port("t5_after", 4'b0001, 1'b1, 8'h10);
      chk("t5_after_locked", 32'(locked), 32'd0);
      tick();
      valid = 4'b0000; d1 = 8'h21;
      expect_fifo("t5_fifo_c1", 8'hC1);
      expect_fifo("t5_fifo_r0", 8'h10);

      // 6: owner 2 goes silent (rr_ptr=1)
      valid = 4'b0100; last = 4'b0000; d2 = 8'hD1;
      #1;
      chk_port("t6_d1", 4'b0100, 1'b1, 8'hD1);
      tick();
      valid = 4'b0001; last = 4'b0001;
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         #1;
         chk_port("t6_idle", 4'b0000, 1'b0, 8'h00);
         chk("t6_locked", 32'(locked), 32'd1);
         chk("t6_tmo_low", 32'(timeout_err), 32'd0);
         tick();
      end
      #1;
      chk("t6_tmo_pulse", 32'(timeout_err), 32'd1);
      chk("t6_released", 32'(locked), 32'd0);
      chk_port("t6_next", 4'b0001, 1'b1, 8'h10);
      tick();
      chk("t6_tmo_end", 32'(timeout_err), 32'd0);
      valid = 4'b0000; d2 = 8'h32; last = 4'b1111;
      expect_fifo("t6_fifo_d1", 8'hD1);
      expect_fifo("t6_fifo_r0", 8'h10);
`else
      for (int i = 0; i < 20; i++) begin
         #1;
         chk_port("t6_idle", 4'b0000, 1'b0, 8'h00);
         chk("t6_locked", 32'(locked), 32'd1);
         chk("t6_tmo_zero", 32'(timeout_err), 32'd0);
         tick();
      end
      valid = 4'b0101; last = 4'b0101; d2 = 8'hD2;
      #1;
      chk("t6_lock_id", 32'(lock_id), 32'd2);
      chk_port("t6_d2", 4'b0100, 1'b1, 8'hD2);
      tick();
      valid = 4'b0000; d2 = 8'h32; last = 4'b1111;
      expect_fifo("t6_fifo_d1", 8'hD1);
      expect_fifo("t6_fifo_d2", 8'hD2);
`endif
      chk("end_empty", 32'(fcnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
